// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF types: result payload, ID width and the core-side result classification.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef enum logic [1:0] {
    RES_NORMAL,
    RES_KILL,
    RES_SPURIOUS
  } result_class_e;

  // A result for an ID that is not pending is spurious even if a kill targets it.
  function automatic result_class_e classify(input logic pending,
                                             input logic killed,
                                             input logic kill_fwd);
    if (!pending)               return RES_SPURIOUS;
    else if (killed || kill_fwd) return RES_KILL;
    else                        return RES_NORMAL;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through; push is ignored when full, pop when empty.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] read_q;
  logic [ADDR_DEPTH-1:0] write_q;
  logic [ADDR_DEPTH:0]   count_q;
  logic                  is_empty;
  logic                  bypass;
  logic                  do_push;
  logic                  do_pop;

  assign is_empty = (count_q == '0);
  assign full_o   = (count_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o  = is_empty && !(FALL_THROUGH && push_i);
  assign bypass   = FALL_THROUGH && is_empty && push_i && pop_i;
  assign do_push  = push_i && !full_o && !bypass;
  assign do_pop   = pop_i && !empty_o && !bypass;
  assign data_o   = (FALL_THROUGH && is_empty) ? data_i : mem_q[read_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_q  <= '0;
      write_q <= '0;
      count_q <= '0;
      // NOTE: storage is reset so the head word reads all-zero out of reset; flush only moves pointers.
      mem_q   <= '{default: '0};
    end else if (flush_i) begin
      read_q  <= '0;
      write_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[write_q] <= data_i;
        write_q <= (write_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : write_q + ADDR_DEPTH'(1);
      end
      if (do_pop) begin
        read_q <= (read_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : read_q + ADDR_DEPTH'(1);
      end
      if (do_push && !do_pop)      count_q <= count_q + (ADDR_DEPTH+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (ADDR_DEPTH+1)'(1);
    end
  end

endmodule

// File: rtl/cvxif_result_buffer.sv
// Core-side CV-X-IF result stage: tracks offloaded IDs, drops killed/spurious results,
// and buffers the rest in order for the writeback port.
module cvxif_result_buffer
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_NUM = 2**X_ID_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  issue_valid_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  x_result_t             x_result_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output x_result_t             wb_result_o,
  output logic [X_ID_WIDTH:0]   outstanding_o,
  output logic                  spurious_o
);

  logic [ID_NUM-1:0]   pending_q, pending_d;
  logic [ID_NUM-1:0]   killed_q, killed_d;
  logic [X_ID_WIDTH:0] outstanding_q, outstanding_d;
  logic                spurious_q;
  result_class_e       res_class;
  logic                kill_fwd;
  logic                result_hs;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  x_result_t           head;

  // A kill commit in the same cycle as its result is forwarded so the result is not buffered.
  assign kill_fwd  = commit_valid_i && commit_kill_i && (commit_id_i == x_result_i.id);
  assign res_class = classify(pending_q[x_result_i.id], killed_q[x_result_i.id], kill_fwd);

  assign x_result_ready_o = !flush_i && (!fifo_full || (res_class != RES_NORMAL));
  assign result_hs        = x_result_valid_i && x_result_ready_o;
  assign push             = result_hs && (res_class == RES_NORMAL);
  assign wb_valid_o       = !fifo_empty;
  assign pop              = wb_valid_o && wb_ready_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (DEPTH),
    .dtype        (x_result_t)
  ) i_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (x_result_i),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pending_d     = pending_q;
    killed_d      = killed_q;
    outstanding_d = '0;
    if (flush_i) begin
      pending_d = '0;
      killed_d  = '0;
    end else begin
      if (commit_valid_i && commit_kill_i && pending_q[commit_id_i]) begin
        killed_d[commit_id_i] = 1'b1;
      end
      if (result_hs && (res_class != RES_SPURIOUS)) begin
        pending_d[x_result_i.id] = 1'b0;
        killed_d[x_result_i.id]  = 1'b0;
      end
      // Issue is applied last so a same-cycle spurious result cannot undo it.
      if (issue_valid_i) begin
        pending_d[issue_id_i] = 1'b1;
        killed_d[issue_id_i]  = 1'b0;
      end
    end
    for (int i = 0; i < ID_NUM; i++) begin
      outstanding_d = outstanding_d + (X_ID_WIDTH+1)'(pending_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q     <= '0;
      killed_q      <= '0;
      outstanding_q <= '0;
      spurious_q    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      pending_q     <= pending_d;
      killed_q      <= killed_d;
      outstanding_q <= outstanding_d;
      spurious_q    <= result_hs && (res_class == RES_SPURIOUS);
    end
  end

  always_comb begin
    wb_result_o    = head;
    wb_result_o.we = head.we && wb_valid_o;
  end

  assign outstanding_o = outstanding_q;
  assign spurious_o    = spurious_q;

  issue_to_pending_id: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (issue_valid_i && !flush_i) |-> !pending_q[issue_id_i]
  );

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed bench for cvxif_result_buffer: a per-cycle vector table plus hand-written
// sequences for FIFO-full ordering, kill-while-full, flush and asynchronous reset.
module tb_cvxif_result_buffer;
  import cvxif_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  flush_i;
  logic                  issue_valid_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;
  logic                  x_result_valid_i;
  logic                  x_result_ready_o;
  x_result_t             x_result_i;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  x_result_t             wb_result_o;
  logic [X_ID_WIDTH:0]   outstanding_o;
  logic                  spurious_o;

  int n_checks = 0;
  int n_fail   = 0;

  cvxif_result_buffer #(.DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_id_i       (issue_id_i),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_i       (x_result_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .outstanding_o    (outstanding_o),
    .spurious_o       (spurious_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [3:0]  iid;
    logic        cv;
    logic [3:0]  cid;
    logic        ck;
    logic        rv;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [4:0]  rrd;
    logic        wbr;
    logic        e_rdy;
    logic        e_wbv;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic [4:0]  e_out;
    logic        e_sp;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t v(input logic iv, input logic [3:0] iid, input logic cv,
                             input logic [3:0] cid, input logic ck, input logic rv,
                             input logic [3:0] rid, input logic [31:0] rdata,
                             input logic [4:0] rrd, input logic wbr, input logic e_rdy,
                             input logic e_wbv, input logic [31:0] e_data,
                             input logic [4:0] e_rd, input logic [4:0] e_out,
                             input logic e_sp);
    vec_t r;
    r.iv = iv; r.iid = iid; r.cv = cv; r.cid = cid; r.ck = ck;
    r.rv = rv; r.rid = rid; r.rdata = rdata; r.rrd = rrd; r.wbr = wbr;
    r.e_rdy = e_rdy; r.e_wbv = e_wbv; r.e_data = e_data; r.e_rd = e_rd;
    r.e_out = e_out; r.e_sp = e_sp;
    return r;
  endfunction

  function automatic x_result_t mk_res(input logic [3:0] id, input logic [31:0] data,
                                       input logic [4:0] rd);
    x_result_t r;
    r.id = id; r.data = data; r.rd = rd; r.we = 1'b1; r.exc = 1'b0; r.exccode = 6'h0;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge and drop all single-cycle strobes; wb_ready_i persists.
  task automatic next_cycle();
    @(negedge clk_i);
    issue_valid_i    = 1'b0;
    commit_valid_i   = 1'b0;
    commit_kill_i    = 1'b0;
    x_result_valid_i = 1'b0;
    flush_i          = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_id_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    x_result_valid_i = 1'b0; x_result_i = '0; wb_ready_i = 1'b0;

    //        iv iid cv cid ck rv rid rdata  rrd wbr rdy wbv e_data e_rd out sp
    vecs[0]  = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[1]  = v(1, 3, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[2]  = v(0, 0, 0, 0, 0, 1, 3, 32'h2A, 5, 1,  1,  0, 32'h0,  0, 1, 0);
    vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  1, 32'h2A, 5, 0, 0);
    vecs[4]  = v(1, 7, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[5]  = v(0, 0, 1, 7, 1, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 1, 0);
    vecs[6]  = v(0, 0, 0, 0, 0, 1, 7, 32'h77, 7, 1,  1,  0, 32'h0,  0, 1, 0);
    vecs[7]  = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[8]  = v(0, 0, 0, 0, 0, 1, 9, 32'h99, 9, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 1);
    vecs[10] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[11] = v(1, 5, 0, 0, 0, 1, 5, 32'h55, 1, 0,  1,  0, 32'h0,  0, 0, 0);
    vecs[12] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0,  1,  0, 32'h0,  0, 1, 1);
    vecs[13] = v(0, 0, 0, 0, 0, 1, 5, 32'h55, 1, 0,  1,  0, 32'h0,  0, 1, 0);
    vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  1, 32'h55, 1, 0, 0);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);
    vecs[16] = v(1, 6, 0, 0, 0, 0, 0, 32'h0,  0, 0,  1,  0, 32'h0,  0, 0, 0);
    vecs[17] = v(0, 0, 1, 6, 0, 0, 0, 32'h0,  0, 0,  1,  0, 32'h0,  0, 1, 0);
    vecs[18] = v(0, 0, 0, 0, 0, 1, 6, 32'h66, 6, 0,  1,  0, 32'h0,  0, 1, 0);
    vecs[19] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0,  1,  1, 32'h66, 6, 0, 0);
    vecs[20] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  1, 32'h66, 6, 0, 0);
    vecs[21] = v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 1,  1,  0, 32'h0,  0, 0, 0);

    // Reset values
    #3;
    check("rst_ready", x_result_ready_o, 1'b1);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_result", wb_result_o, '0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_spurious", spurious_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Table: single result, kill, spurious, same-cycle issue/result, non-kill commit
    for (int i = 0; i < 22; i++) begin
      next_cycle();
      issue_valid_i = vecs[i].iv; issue_id_i = vecs[i].iid;
      commit_valid_i = vecs[i].cv; commit_id_i = vecs[i].cid; commit_kill_i = vecs[i].ck;
      x_result_valid_i = vecs[i].rv;
      x_result_i = mk_res(vecs[i].rid, vecs[i].rdata, vecs[i].rrd);
      wb_ready_i = vecs[i].wbr;
      #1;
      check($sformatf("vec%0d_ready", i), x_result_ready_o, vecs[i].e_rdy);
      check($sformatf("vec%0d_wb_valid", i), wb_valid_o, vecs[i].e_wbv);
      check($sformatf("vec%0d_outstanding", i), outstanding_o, vecs[i].e_out);
      check($sformatf("vec%0d_spurious", i), spurious_o, vecs[i].e_sp);
      if (vecs[i].e_wbv) begin
        check($sformatf("vec%0d_wb_data", i), wb_result_o.data, vecs[i].e_data);
        check($sformatf("vec%0d_wb_rd", i), wb_result_o.rd, vecs[i].e_rd);
        check($sformatf("vec%0d_wb_we", i), wb_result_o.we, 1'b1);
      end else begin
        check($sformatf("vec%0d_we_masked", i), wb_result_o.we, 1'b0);
      end
    end

    // Fill to full with ids 0..3, id 4 must wait, then drain in order
    wb_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_cycle(); issue_valid_i = 1'b1; issue_id_i = 4'(k);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle(); x_result_valid_i = 1'b1; x_result_i = mk_res(4'(k), 32'h100 + k, 5'(k));
      #1 check($sformatf("fill%0d_ready", k), x_result_ready_o, 1'b1);
    end
    next_cycle(); x_result_valid_i = 1'b1; x_result_i = mk_res(4'd4, 32'h104, 5'd4);
    #1;
    check("full_ready", x_result_ready_o, 1'b0);
    check("full_outstanding", outstanding_o, 1);
    begin
      logic accepted = 1'b0;
      int   ndel = 0;
      for (int c = 0; c < 20 && ndel < 5; c++) begin
        next_cycle();
        wb_ready_i = 1'b1;
        if (!accepted) begin
          x_result_valid_i = 1'b1; x_result_i = mk_res(4'd4, 32'h104, 5'd4);
        end
        #1;
        if (c == 0) check("full_pop_ready", x_result_ready_o, 1'b0);
        if (x_result_valid_i && x_result_ready_o) accepted = 1'b1;
        if (wb_valid_o) begin
          check($sformatf("order%0d_data", ndel), wb_result_o.data, 32'h100 + ndel);
          ndel++;
        end
      end
      check("order_count", ndel, 5);
      check("order_id4_accepted", accepted, 1'b1);
    end

    // Kill commit and result for id 2 in the same cycle while full
    next_cycle(); wb_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_cycle(); issue_valid_i = 1'b1; issue_id_i = (k == 4) ? 4'd2 : 4'(10 + k);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle(); x_result_valid_i = 1'b1; x_result_i = mk_res(4'(10 + k), 32'h10A + k, 5'(k));
    end
    next_cycle();
    commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd2;
    x_result_valid_i = 1'b1; x_result_i = mk_res(4'd2, 32'h102, 5'd2);
    #1;
    check("killfull_ready", x_result_ready_o, 1'b1);
    check("killfull_outstanding_before", outstanding_o, 1);
    next_cycle(); wb_ready_i = 1'b1;
    #1;
    check("killfull_outstanding_after", outstanding_o, 0);
    check("killfull_spurious", spurious_o, 1'b0);
    check("killfull_head", wb_result_o.data, 32'h10A);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      #1 check($sformatf("killfull_drain%0d", k), wb_result_o.data, 32'h10A + k);
    end
    next_cycle();
    #1 check("killfull_no_push", wb_valid_o, 1'b0);

    // Flush with two results buffered and one ID pending
    wb_ready_i = 1'b0;
    next_cycle(); issue_valid_i = 1'b1; issue_id_i = 4'd14;
    next_cycle(); issue_valid_i = 1'b1; issue_id_i = 4'd15;
    next_cycle(); issue_valid_i = 1'b1; issue_id_i = 4'd1;
    next_cycle(); x_result_valid_i = 1'b1; x_result_i = mk_res(4'd14, 32'h10E, 5'd14);
    next_cycle(); x_result_valid_i = 1'b1; x_result_i = mk_res(4'd15, 32'h10F, 5'd15);
    next_cycle();
    flush_i = 1'b1; issue_valid_i = 1'b1; issue_id_i = 4'd0;
    x_result_valid_i = 1'b1; x_result_i = mk_res(4'd1, 32'h101, 5'd1);
    #1;
    check("flush_ready", x_result_ready_o, 1'b0);
    check("flush_wb_valid_before", wb_valid_o, 1'b1);
    check("flush_outstanding_before", outstanding_o, 1);
    next_cycle();
    #1;
    check("flush_wb_valid_after", wb_valid_o, 1'b0);
    check("flush_outstanding_after", outstanding_o, 0);
    check("flush_we_masked", wb_result_o.we, 1'b0);

    // Asynchronous reset mid-stream
    next_cycle(); issue_valid_i = 1'b1; issue_id_i = 4'd3;
    next_cycle(); x_result_valid_i = 1'b1; x_result_i = mk_res(4'd3, 32'h3C, 5'd3);
    next_cycle(); issue_valid_i = 1'b1; issue_id_i = 4'd4;
    x_result_valid_i = 1'b1; x_result_i = mk_res(4'd9, 32'h99, 5'd9);
    next_cycle();
    #1;
    check("pre_rst_wb_valid", wb_valid_o, 1'b1);
    check("pre_rst_spurious", spurious_o, 1'b1);
    check("pre_rst_outstanding", outstanding_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_wb_valid", wb_valid_o, 1'b0);
    check("mid_rst_wb_result", wb_result_o, '0);
    check("mid_rst_outstanding", outstanding_o, 0);
    check("mid_rst_spurious", spurious_o, 1'b0);
    check("mid_rst_ready", x_result_ready_o, 1'b1);
    next_cycle(); rst_ni = 1'b1;
    next_cycle();
    #1;
    check("post_rst_wb_valid", wb_valid_o, 1'b0);
    check("post_rst_outstanding", outstanding_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
